// File: rtl/pmp_cfg_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pmp_cfg_regs_pkg
// Description : PMP configuration types and CSR base addresses shared by the
//               PMP register block and its legalisation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pmp_cfg_regs_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmp_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmp_access_t    access_type;
    } pmpcfg_t;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

endpackage
`default_nettype wire

// File: rtl/pmp_cfg_legalize.sv
`default_nettype none
// ============================================================================
// Module      : pmp_cfg_legalize
// Description : Combinational WARL legalisation of one written pmpcfg byte
//               against the currently committed entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pmp_cfg_legalize
    import pmp_cfg_regs_pkg::*;
(
    input  logic [7:0] i_wbyte,
    input  pmpcfg_t    i_old_cfg,
    input  logic       i_in_range,
    output pmpcfg_t    o_new_cfg,
    output logic       o_write_en
);

    always_comb begin
        o_new_cfg          = pmpcfg_t'(i_wbyte);
        o_new_cfg.reserved = 2'b00;
        // W without R is a reserved combination; drop W
        if (!o_new_cfg.access_type.r && o_new_cfg.access_type.w) begin
            o_new_cfg.access_type.w = 1'b0;
        end
        o_write_en = i_in_range && !i_old_cfg.locked;
    end

endmodule
`default_nettype wire

// File: rtl/pmp_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : pmp_cfg_regs
// Description : pmpcfg/pmpaddr CSR storage with lock rules, byte-serial cfg
//               walk into a shadow copy, atomic commit and flush request.
// Revision    : 1.0 - initial release
// ============================================================================
module pmp_cfg_regs
    import pmp_cfg_regs_pkg::*;
#(
    parameter int unsigned NR_PMP_ENTRIES = 16,
    parameter int unsigned PLEN           = 56,
    parameter int unsigned XLEN           = 64,
    localparam int unsigned NR_PORT       = (NR_PMP_ENTRIES > 0) ? NR_PMP_ENTRIES : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            csr_valid_i,
    output logic                            csr_ready_o,
    input  logic                            csr_we_i,
    input  logic [11:0]                     csr_addr_i,
    input  logic [XLEN-1:0]                 csr_wdata_i,
    output logic                            rdata_valid_o,
    output logic [XLEN-1:0]                 csr_rdata_o,
    output logic                            csr_err_o,
    output logic [NR_PORT-1:0][PLEN-3:0]    conf_addr_o,
    output pmpcfg_t [NR_PORT-1:0]           conf_o,
    output logic                            flush_o,
    input  logic                            flush_ack_i
);

    localparam int unsigned c_BYTES = XLEN / 8;
    localparam int unsigned c_CNT_W = $clog2(c_BYTES);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ADDR     = 3'd1;
    localparam logic [2:0] c_CFG_WALK = 3'd2;
    localparam logic [2:0] c_COMMIT   = 3'd3;
    localparam logic [2:0] c_FLUSH    = 3'd4;

    logic [2:0]                   r_state;
    logic [c_CNT_W-1:0]           r_cnt;
    logic [3:0]                   r_cfg_idx;
    logic [5:0]                   r_addr_idx;
    logic [XLEN-1:0]              r_wdata;
    pmpcfg_t [NR_PORT-1:0]        r_conf;
    pmpcfg_t [NR_PORT-1:0]        r_shadow_cfg;
    logic [NR_PORT-1:0][PLEN-3:0] r_conf_addr;
    logic [NR_PORT-1:0][PLEN-3:0] r_shadow_addr;
    logic                         r_rdata_valid;
    logic                         r_err;
    logic [XLEN-1:0]              r_rdata;

    logic            w_is_cfg;
    logic            w_is_addr;
    logic            w_illegal;
    logic [11:0]     w_addr_off;
    logic [XLEN-1:0] w_rdata;
    logic [6:0]      w_entry;
    logic [7:0]      w_wbyte;
    logic            w_in_range;
    pmpcfg_t         w_old_cfg;
    pmpcfg_t         w_new_cfg;
    logic            w_cfg_we;
    logic            w_addr_locked;
    logic            w_changed;

    assign w_is_cfg   = (csr_addr_i[11:4] == CSR_PMPCFG0[11:4]);
    assign w_addr_off = csr_addr_i - CSR_PMPADDR0;
    assign w_is_addr  = (csr_addr_i >= CSR_PMPADDR0) && (csr_addr_i <= (CSR_PMPADDR0 + 12'd63));
    // RV64 only exposes the even pmpcfg registers
    assign w_illegal  = !((w_is_cfg && !((XLEN == 64) && csr_addr_i[0])) || w_is_addr);

    always_comb begin
        w_rdata = '0;
        if (w_is_cfg) begin
            for (int k = 0; k < int'(c_BYTES); k++) begin
                for (int i = 0; i < int'(NR_PORT); i++) begin
                    if (i < int'(NR_PMP_ENTRIES) && (4 * int'(csr_addr_i[3:0]) + k) == i) begin
                        w_rdata[8*k +: 8] = r_conf[i] & 8'h9F;
                    end
                end
            end
        end else if (w_is_addr) begin
            for (int i = 0; i < int'(NR_PORT); i++) begin
                if (i < int'(NR_PMP_ENTRIES) && int'(w_addr_off[5:0]) == i) begin
                    w_rdata = XLEN'(r_conf_addr[i]);
                end
            end
        end
        if (w_illegal) begin
            w_rdata = '0;
        end
    end

    assign w_entry    = 7'({r_cfg_idx, 2'b00}) + 7'(r_cnt);
    assign w_wbyte    = r_wdata[8*r_cnt +: 8];
    assign w_in_range = int'(w_entry) < int'(NR_PMP_ENTRIES);

    always_comb begin
        w_old_cfg = '0;
        for (int i = 0; i < int'(NR_PORT); i++) begin
            if (int'(w_entry) == i) begin
                w_old_cfg = r_conf[i];
            end
        end
    end

    pmp_cfg_legalize u_legalize (
        .i_wbyte    (w_wbyte),
        .i_old_cfg  (w_old_cfg),
        .i_in_range (w_in_range),
        .o_new_cfg  (w_new_cfg),
        .o_write_en (w_cfg_we)
    );

    // An address is frozen by its own lock or by a locked TOR entry above it
    always_comb begin
        w_addr_locked = 1'b0;
        for (int i = 0; i < int'(NR_PORT); i++) begin
            if (i < int'(NR_PMP_ENTRIES)) begin
                if (int'(r_addr_idx) == i && r_conf[i].locked) begin
                    w_addr_locked = 1'b1;
                end
                if (int'(r_addr_idx) + 1 == i && r_conf[i].locked && r_conf[i].addr_mode == TOR) begin
                    w_addr_locked = 1'b1;
                end
            end
        end
    end

    assign w_changed = (r_shadow_cfg != r_conf) || (r_shadow_addr != r_conf_addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_cfg_idx     <= '0;
            r_addr_idx    <= '0;
            r_wdata       <= '0;
            r_conf        <= '0;
            r_shadow_cfg  <= '0;
            r_conf_addr   <= '0;
            r_shadow_addr <= '0;
            r_rdata_valid <= 1'b0;
            r_err         <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_err         <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (csr_valid_i) begin
                        r_wdata    <= csr_wdata_i;
                        r_cfg_idx  <= csr_addr_i[3:0];
                        r_addr_idx <= w_addr_off[5:0];
                        r_cnt      <= '0;
                        if (!csr_we_i) begin
                            r_rdata_valid <= 1'b1;
                            r_rdata       <= w_rdata;
                            r_err         <= w_illegal;
                        end else if (w_illegal) begin
                            r_err <= 1'b1;
                        end else if (w_is_cfg) begin
                            r_state <= c_CFG_WALK;
                        end else begin
                            r_state <= c_ADDR;
                        end
                    end
                end
                c_ADDR: begin
                    for (int i = 0; i < int'(NR_PORT); i++) begin
                        if (i < int'(NR_PMP_ENTRIES) && int'(r_addr_idx) == i && !w_addr_locked) begin
                            r_shadow_addr[i] <= r_wdata[PLEN-3:0];
                        end
                    end
                    r_state <= c_COMMIT;
                end
                c_CFG_WALK: begin
                    for (int i = 0; i < int'(NR_PORT); i++) begin
                        if (w_cfg_we && int'(w_entry) == i) begin
                            r_shadow_cfg[i] <= w_new_cfg;
                        end
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_W'(c_BYTES - 1)) begin
                        r_state <= c_COMMIT;
                    end
                end
                c_COMMIT: begin
                    r_conf      <= r_shadow_cfg;
                    r_conf_addr <= r_shadow_addr;
                    r_state     <= w_changed ? c_FLUSH : c_IDLE;
                end
                c_FLUSH: begin
                    if (flush_ack_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign csr_ready_o   = (r_state == c_IDLE);
    assign flush_o       = (r_state == c_FLUSH);
    assign rdata_valid_o = r_rdata_valid;
    assign csr_rdata_o   = r_rdata;
    assign csr_err_o     = r_err;
    assign conf_o        = r_conf;
    assign conf_addr_o   = r_conf_addr;

endmodule
`default_nettype wire

// File: tb/tb_pmp_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmp_cfg_regs
// Description : Directed and randomised CSR traffic against pmp_cfg_regs with
//               an array-based reference model of the PMP register rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmp_cfg_regs;
    import pmp_cfg_regs_pkg::*;

    localparam int N    = 4;
    localparam int PLEN = 56;
    localparam int XLEN = 64;
    localparam int AW   = PLEN - 2;

    logic                   clk_i       = 1'b0;
    logic                   rst_i       = 1'b1;
    logic                   csr_valid_i = 1'b0;
    logic                   csr_we_i    = 1'b0;
    logic [11:0]            csr_addr_i  = '0;
    logic [XLEN-1:0]        csr_wdata_i = '0;
    logic                   flush_ack_i = 1'b0;
    logic                   csr_ready_o;
    logic                   rdata_valid_o;
    logic [XLEN-1:0]        csr_rdata_o;
    logic                   csr_err_o;
    logic [N-1:0][AW-1:0]   conf_addr_o;
    pmpcfg_t [N-1:0]        conf_o;
    logic                   flush_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]    m_cfg  [N];
    logic [AW-1:0] m_addr [N];

    pmp_cfg_regs #(
        .NR_PMP_ENTRIES (N),
        .PLEN           (PLEN),
        .XLEN           (XLEN)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .csr_valid_i   (csr_valid_i),
        .csr_ready_o   (csr_ready_o),
        .csr_we_i      (csr_we_i),
        .csr_addr_i    (csr_addr_i),
        .csr_wdata_i   (csr_wdata_i),
        .rdata_valid_o (rdata_valid_o),
        .csr_rdata_o   (csr_rdata_o),
        .csr_err_o     (csr_err_o),
        .conf_addr_o   (conf_addr_o),
        .conf_o        (conf_o),
        .flush_o       (flush_o),
        .flush_ack_i   (flush_ack_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] m_conf_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[8*i +: 8] = m_cfg[i];
        return v;
    endfunction

    function automatic logic [255:0] m_addr_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[AW*i +: AW] = m_addr[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cfg[i]  = '0;
            m_addr[i] = '0;
        end
    endtask

    task automatic model_write(input logic [11:0] a, input logic [63:0] d,
                               output bit err, output bit chg, output bit is_cfg);
        logic [255:0] oc, oa;
        logic [7:0]   b;
        int           n, m, e;
        oc = m_conf_vec();
        oa = m_addr_vec();
        err = 0;
        is_cfg = 0;
        if (a >= 12'h3A0 && a <= 12'h3AF) begin
            n = int'(a) - 'h3A0;
            if (n % 2 == 1) err = 1;
            else begin
                is_cfg = 1;
                for (int k = 0; k < XLEN / 8; k++) begin
                    e = 4 * n + k;
                    if (e < N && !m_cfg[e][7]) begin
                        b = d[8*k +: 8];
                        b[6:5] = 2'b00;
                        if (b[1:0] == 2'b10) b[1] = 1'b0;
                        m_cfg[e] = b;
                    end
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
            m = int'(a) - 'h3B0;
            if (m < N && !m_cfg[m][7] &&
                !(m + 1 < N && m_cfg[m+1][7] && m_cfg[m+1][4:3] == 2'b01)) begin
                m_addr[m] = d[AW-1:0];
            end
        end else begin
            err = 1;
        end
        chg = (oc != m_conf_vec()) || (oa != m_addr_vec());
    endtask

    task automatic model_read(input logic [11:0] a, output logic [63:0] d, output bit err);
        int n, m;
        d = '0;
        err = 0;
        if (a >= 12'h3A0 && a <= 12'h3AF) begin
            n = int'(a) - 'h3A0;
            if (n % 2 == 1) err = 1;
            else for (int k = 0; k < XLEN / 8; k++) begin
                if (4 * n + k < N) d[8*k +: 8] = m_cfg[4*n+k];
            end
        end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
            m = int'(a) - 'h3B0;
            if (m < N) d = 64'(m_addr[m]);
        end else begin
            err = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        csr_valid_i = 1'b0;
        flush_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
    endtask

    // Returns at the falling edge of the cycle after acceptance
    task automatic issue(input logic we, input logic [11:0] a, input logic [63:0] d);
        int n;
        n = 0;
        while (!csr_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!csr_ready_o) check("ready_timeout", 256'(csr_ready_o), 256'(1));
        csr_valid_i = 1'b1;
        csr_we_i    = we;
        csr_addr_i  = a;
        csr_wdata_i = d;
        @(negedge clk_i);
        csr_valid_i = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a);
        logic [63:0] exp_d;
        bit          exp_err;
        model_read(a, exp_d, exp_err);
        issue(1'b0, a, '0);
        check("rd_valid", 256'(rdata_valid_o), 256'(1));
        check("rd_err", 256'(csr_err_o), 256'(exp_err));
        if (!exp_err) check("rd_data", 256'(csr_rdata_o), 256'(exp_d));
        @(negedge clk_i);
        check("rd_valid_pulse", 256'(rdata_valid_o), 256'(0));
    endtask

    task automatic do_write(input logic [11:0] a, input logic [63:0] d, input int h);
        bit err, chg, isc, ok;
        int lat, pulses;
        model_write(a, d, err, chg, isc);
        issue(1'b1, a, d);
        if (err) begin
            pulses = int'(csr_err_o);
            @(negedge clk_i);
            pulses += int'(csr_err_o);
            @(negedge clk_i);
            pulses += int'(csr_err_o);
            check("werr_pulse", 256'(pulses), 256'(1));
            check("werr_conf", 256'(conf_o), m_conf_vec());
            check("werr_addr", 256'(conf_addr_o), m_addr_vec());
            check("werr_ready", 256'(csr_ready_o), 256'(1));
            return;
        end
        lat = isc ? (XLEN / 8 + 2) : 3;
        ok = 1;
        for (int c = 1; c < lat; c++) begin
            if (csr_ready_o || flush_o || csr_err_o) ok = 0;
            @(negedge clk_i);
        end
        check("busy", 256'(ok), 256'(1));
        check("conf", 256'(conf_o), m_conf_vec());
        check("conf_addr", 256'(conf_addr_o), m_addr_vec());
        check("flush", 256'(flush_o), 256'(chg));
        if (!chg) begin
            check("ready_nochg", 256'(csr_ready_o), 256'(1));
        end else begin
            if (h > 0) begin
                ok = 1;
                for (int j = 0; j < h; j++) begin
                    @(negedge clk_i);
                    if (!flush_o || csr_ready_o) ok = 0;
                end
                check("flush_hold", 256'(ok), 256'(1));
            end
            flush_ack_i = 1'b1;
            @(negedge clk_i);
            flush_ack_i = 1'b0;
            check("ack_ready", 256'(csr_ready_o), 256'(1));
            check("ack_flush", 256'(flush_o), 256'(0));
        end
    endtask

    initial begin
        logic [11:0] a;
        logic [63:0] d;
        int          sel;

        model_reset();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_conf", 256'(conf_o), 256'(0));
        check("rst_addr", 256'(conf_addr_o), 256'(0));
        check("rst_ready", 256'(csr_ready_o), 256'(1));
        check("rst_rvalid", 256'(rdata_valid_o), 256'(0));
        check("rst_err", 256'(csr_err_o), 256'(0));
        check("rst_flush", 256'(flush_o), 256'(0));

        do_read(12'h3A0);
        do_write(12'h3B0, 64'h1000, 0);
        check("addr0_val", 256'(conf_addr_o[0]), 256'(64'h1000));
        do_write(12'h3A0, 64'h0A, 1);
        check("cfg0_wclr", 256'(conf_o[0]), 256'(8'h08));
        do_read(12'h3A0);

        do_write(12'h3A0, 64'h8808, 0);
        do_write(12'h3B0, 64'h2000, 0);
        do_write(12'h3B1, 64'h3000, 0);
        check("locked_addr0", 256'(conf_addr_o[0]), 256'(64'h1000));
        do_read(12'h3B0);

        do_write(12'h3A1, 64'hFF, 0);
        do_read(12'h3A1);
        do_read(12'h3F0);

        do_reset();
        do_write(12'h3A0, 64'hFFFF_FFFF_0F0F_0F0F, 0);
        do_read(12'h3A0);
        check("cfg_n4_read", 256'(csr_rdata_o), 256'(64'h0F0F_0F0F));

        issue(1'b1, 12'h3A0, 64'h0909_0909_0909_0909);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        check("midwalk_conf", 256'(conf_o), 256'(0));
        check("midwalk_ready", 256'(csr_ready_o), 256'(1));
        check("midwalk_flush", 256'(flush_o), 256'(0));

        do_write(12'h3B2, 64'hABCD, 5);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                sel = $urandom_range(0, 9);
                if (sel < 4)       a = 12'h3A0 + 12'($urandom_range(0, 15));
                else if (sel < 8)  a = 12'h3B0 + 12'($urandom_range(0, 7));
                else if (sel == 8) a = 12'h3B0 + 12'($urandom_range(0, 63));
                else               a = 12'($urandom_range(0, 4095));
                d = {32'($urandom), 32'($urandom)};
                for (int k = 0; k < 8; k++) begin
                    if ($urandom_range(0, 15) != 0) d[8*k+7] = 1'b0;
                end
                if ($urandom_range(0, 2) == 0) do_read(a);
                else do_write(a, d, $urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
